// File: rtl/simplez_ctrl_if.sv
// Simplez memory-side bus between the control unit and the memory/address mux.
//   mem_rd  : memory read request, held until mem_ack
//   mem_wr  : memory write request, held until mem_ack
//   ra_sel  : RA source select, 0 = CP, 1 = RI address field CD
//   mem_ack : memory completion, only meaningful while a request is up
// master = control unit side, slave = memory side.
interface simplez_ctrl_if;
    logic mem_rd;
    logic mem_wr;
    logic ra_sel;
    logic mem_ack;

    modport master (
        output mem_rd,
        output mem_wr,
        output ra_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_rd,
        input  mem_wr,
        input  ra_sel,
        output mem_ack
    );
endinterface

// File: rtl/simplez_ctrl.sv
// Simplez CPU control unit: sequences fetch / decode / execute of the
// 8-instruction ISA and drives the datapath register strobes.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   opcode[2:0]        : RI[11:9], valid from DECODE onwards
//   zero               : AC == 0 flag
//   run, step          : free-run level / single-instruction pulse
//   bus (master)       : mem_rd, mem_wr, ra_sel out; mem_ack in
//   cp_clr/inc/load    : CP strobes (at most one active)
//   ri_load            : RI load from memory data
//   ac_ld/add/clr/dec  : AC strobes (at most one active)
//   stop               : 1 while halted
//   state[2:0]         : debug state code
module simplez_ctrl (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            opcode,
    input  logic                  zero,
    input  logic                  run,
    input  logic                  step,
    simplez_ctrl_if.master        bus,
    output logic                  cp_clr,
    output logic                  cp_inc,
    output logic                  cp_load,
    output logic                  ri_load,
    output logic                  ac_ld,
    output logic                  ac_add,
    output logic                  ac_clr,
    output logic                  ac_dec,
    output logic                  stop,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEMRD  = 3'd3,
        S_MEMWR  = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [2:0] OP_ST   = 3'b000;
    localparam logic [2:0] OP_LD   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_BR   = 3'b011;
    localparam logic [2:0] OP_BZ   = 3'b100;
    localparam logic [2:0] OP_CLR  = 3'b101;
    localparam logic [2:0] OP_DEC  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t state_reg, state_next;
    logic   step_pend_reg, step_pend_next;
    // Remembers that the fetch request is already on the bus, so a run
    // drop while waiting for ack cannot withdraw the request.
    logic   fetch_busy_reg, fetch_busy_next;
    logic   go;
    logic   mem_rd, mem_wr, ra_sel;

    assign go         = run | step_pend_reg;
    assign bus.mem_rd = mem_rd;
    assign bus.mem_wr = mem_wr;
    assign bus.ra_sel = ra_sel;
    assign state      = state_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_INIT;
            step_pend_reg  <= 1'b0;
            fetch_busy_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            step_pend_reg  <= step_pend_next;
            fetch_busy_reg <= fetch_busy_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        step_pend_next  = step_pend_reg;
        fetch_busy_next = fetch_busy_reg;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        ra_sel  = 1'b0;
        cp_clr  = 1'b0;
        cp_inc  = 1'b0;
        cp_load = 1'b0;
        ri_load = 1'b0;
        ac_ld   = 1'b0;
        ac_add  = 1'b0;
        ac_clr  = 1'b0;
        ac_dec  = 1'b0;
        stop    = 1'b0;

        // A step while one is already pending simply re-sets the flag.
        if (step && state_reg != S_HALT) begin
            step_pend_next = 1'b1;
        end

        case (state_reg)
            S_INIT: begin
                cp_clr     = 1'b1;
                state_next = S_FETCH;
            end
            S_FETCH: begin
                if (go || fetch_busy_reg) begin
                    mem_rd = 1'b1;
                    if (bus.mem_ack) begin
                        ri_load         = 1'b1;
                        cp_inc          = 1'b1;
                        state_next      = S_DECODE;
                        // Completing fetch consumes the step (wins over a
                        // coincident step pulse).
                        step_pend_next  = 1'b0;
                        fetch_busy_next = 1'b0;
                    end else begin
                        fetch_busy_next = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_ST:   state_next = S_MEMWR;
                    OP_LD,
                    OP_ADD:  state_next = S_MEMRD;
                    OP_BR: begin
                        cp_load    = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_BZ: begin
                        cp_load    = zero;
                        state_next = S_FETCH;
                    end
                    OP_CLR: begin
                        ac_clr     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_DEC: begin
                        ac_dec     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_HALT: state_next = S_HALT;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMRD: begin
                ra_sel = 1'b1;
                mem_rd = 1'b1;
                if (bus.mem_ack) begin
                    if (opcode == OP_LD) begin
                        ac_ld = 1'b1;
                    end else begin
                        ac_add = 1'b1;
                    end
                    state_next = S_FETCH;
                end
            end
            S_MEMWR: begin
                ra_sel = 1'b1;
                mem_wr = 1'b1;
                if (bus.mem_ack) begin
                    state_next = S_FETCH;
                end
            end
            S_HALT: begin
                stop = 1'b1;
            end
            default: begin
                state_next = S_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_simplez_ctrl.sv
module tb_simplez_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       zero, run, step;
    logic       cp_clr, cp_inc, cp_load, ri_load;
    logic       ac_ld, ac_add, ac_clr, ac_dec, stop;
    logic [2:0] state;

    simplez_ctrl_if bus();

    simplez_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .zero    (zero),
        .run     (run),
        .step    (step),
        .bus     (bus),
        .cp_clr  (cp_clr),
        .cp_inc  (cp_inc),
        .cp_load (cp_load),
        .ri_load (ri_load),
        .ac_ld   (ac_ld),
        .ac_add  (ac_add),
        .ac_clr  (ac_clr),
        .ac_dec  (ac_dec),
        .stop    (stop),
        .state   (state)
    );

    always #5 clk = ~clk;

    // Output vector bit positions
    localparam logic [11:0] O_STOP  = 12'h800;
    localparam logic [11:0] O_RD    = 12'h400;
    localparam logic [11:0] O_WR    = 12'h200;
    localparam logic [11:0] O_RAS   = 12'h100;
    localparam logic [11:0] O_CPCLR = 12'h080;
    localparam logic [11:0] O_CPINC = 12'h040;
    localparam logic [11:0] O_CPLD  = 12'h020;
    localparam logic [11:0] O_RILD  = 12'h010;
    localparam logic [11:0] O_ACLD  = 12'h008;
    localparam logic [11:0] O_ACADD = 12'h004;
    localparam logic [11:0] O_ACCLR = 12'h002;
    localparam logic [11:0] O_ACDEC = 12'h001;
    localparam logic [11:0] O_FDONE = O_RD | O_RILD | O_CPINC;

    logic [11:0] outs;
    assign outs = {stop, bus.mem_rd, bus.mem_wr, bus.ra_sel, cp_clr, cp_inc,
                   cp_load, ri_load, ac_ld, ac_add, ac_clr, ac_dec};

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [11:0] o;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Push the expected cycle, sample mid-cycle, pop and compare, then move
    // to just after the next rising edge.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [11:0] o);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.o   = o;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        assert ({state, outs} === {e.st, e.o}) else begin
            errors++;
            $error("FAIL %s: state/outs got %0d/%03h expected %0d/%03h",
                   e.tag, state, outs, e.st, e.o);
        end
        $display("t=%0t %s state=%0d outs=%03h", $time, e.tag, state, outs);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run = 1'b1; step = 1'b0; zero = 1'b0;
        opcode = 3'b101; bus.mem_ack = 1'b1;
        @(posedge clk);
        #1;

        // Reset and free-running CLR with zero-wait memory
        cyc("reset", 3'd0, O_CPCLR);
        rst = 1'b0;
        cyc("init", 3'd0, O_CPCLR);
        for (int i = 0; i < 3; i++) begin
            cyc("clr_fetch", 3'd1, O_FDONE);
            cyc("clr_dec", 3'd2, O_ACCLR);
        end

        // LD with two wait states on both accesses
        opcode = 3'b001; bus.mem_ack = 1'b0;
        cyc("ld_fwait", 3'd1, O_RD);
        cyc("ld_fwait", 3'd1, O_RD);
        bus.mem_ack = 1'b1;
        cyc("ld_fetch", 3'd1, O_FDONE);
        bus.mem_ack = 1'b0;
        cyc("ld_dec", 3'd2, 12'h000);
        cyc("ld_mwait", 3'd3, O_RAS | O_RD);
        cyc("ld_mwait", 3'd3, O_RAS | O_RD);
        bus.mem_ack = 1'b1;
        cyc("ld_mem", 3'd3, O_RAS | O_RD | O_ACLD);

        // ADD zero-wait
        opcode = 3'b010;
        cyc("add_fetch", 3'd1, O_FDONE);
        cyc("add_dec", 3'd2, 12'h000);
        cyc("add_mem", 3'd3, O_RAS | O_RD | O_ACADD);

        // BZ taken / not taken, BR, DEC
        opcode = 3'b100; zero = 1'b1;
        cyc("bz_fetch", 3'd1, O_FDONE);
        cyc("bz_taken", 3'd2, O_CPLD);
        zero = 1'b0;
        cyc("bz_fetch", 3'd1, O_FDONE);
        cyc("bz_not", 3'd2, 12'h000);
        opcode = 3'b011;
        cyc("br_fetch", 3'd1, O_FDONE);
        cyc("br_dec", 3'd2, O_CPLD);
        opcode = 3'b110;
        cyc("dec_fetch", 3'd1, O_FDONE);
        cyc("dec_dec", 3'd2, O_ACDEC);

        // ST zero-wait
        opcode = 3'b000;
        cyc("st_fetch", 3'd1, O_FDONE);
        cyc("st_dec", 3'd2, 12'h000);
        cyc("st_mem", 3'd4, O_RAS | O_WR);

        // run falls while the fetch request waits for ack
        opcode = 3'b101; bus.mem_ack = 1'b0;
        cyc("rf_wait", 3'd1, O_RD);
        run = 1'b0;
        cyc("rf_hold", 3'd1, O_RD);
        bus.mem_ack = 1'b1;
        cyc("rf_fetch", 3'd1, O_FDONE);
        cyc("rf_dec", 3'd2, O_ACCLR);
        cyc("rf_idle", 3'd1, 12'h000);

        // Three single steps, 20 cycles apart
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            cyc("step_pulse", 3'd1, 12'h000);
            step = 1'b0;
            cyc("step_fetch", 3'd1, O_FDONE);
            cyc("step_dec", 3'd2, O_ACCLR);
            for (int j = 0; j < 17; j++) begin
                cyc("step_idle", 3'd1, 12'h000);
            end
        end

        // A step during DECODE yields exactly one extra instruction
        step = 1'b1;
        cyc("s2_pulse", 3'd1, 12'h000);
        step = 1'b0;
        cyc("s2_fetch", 3'd1, O_FDONE);
        step = 1'b1;
        cyc("s2_dec_step", 3'd2, O_ACCLR);
        step = 1'b0;
        cyc("s2_extra_fetch", 3'd1, O_FDONE);
        cyc("s2_extra_dec", 3'd2, O_ACCLR);
        cyc("s2_idle", 3'd1, 12'h000);
        cyc("s2_idle", 3'd1, 12'h000);

        // A step while one is pending is absorbed
        step = 1'b1;
        cyc("abs_pulse", 3'd1, 12'h000);
        bus.mem_ack = 1'b0;
        cyc("abs_wait", 3'd1, O_RD);
        step = 1'b0; bus.mem_ack = 1'b1;
        cyc("abs_fetch", 3'd1, O_FDONE);
        cyc("abs_dec", 3'd2, O_ACCLR);
        cyc("abs_idle", 3'd1, 12'h000);
        cyc("abs_idle", 3'd1, 12'h000);

        // HALT: sticky despite run and step
        run = 1'b1; opcode = 3'b111;
        cyc("halt_fetch", 3'd1, O_FDONE);
        cyc("halt_dec", 3'd2, 12'h000);
        for (int i = 0; i < 50; i++) begin
            step = ((i % 7) == 0);
            cyc("halt_hold", 3'd7, O_STOP);
        end
        step = 1'b0; rst = 1'b1;
        cyc("halt_rst_cycle", 3'd7, O_STOP);
        rst = 1'b0; opcode = 3'b001;
        cyc("halt_rst", 3'd0, O_CPCLR);

        // Reset in the middle of a MEMRD
        cyc("mr_fetch", 3'd1, O_FDONE);
        bus.mem_ack = 1'b0;
        cyc("mr_dec", 3'd2, 12'h000);
        cyc("mr_wait", 3'd3, O_RAS | O_RD);
        rst = 1'b1;
        cyc("mr_rst_cycle", 3'd3, O_RAS | O_RD);
        rst = 1'b0; bus.mem_ack = 1'b1;
        cyc("mr_rst_late_ack", 3'd0, O_CPCLR);
        bus.mem_ack = 1'b0;
        cyc("mr_post_fetch", 3'd1, O_RD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/simplez_ctrl.md
# simplez_ctrl

Control unit for the Simplez CPU: a state machine that sequences fetch, decode and execute of the 8-instruction Simplez ISA. It drives the control lines of the datapath registers (CP, RI, AC, RA) and the memory request/acknowledge handshake. It also provides run/single-step gating and the `stop` indication used at the top level.

## Interface
Parameters:
- none. Opcode width is 3 and is fixed by the ISA.

Ports:
- `clk` in 1: system clock. All state changes occur on the rising edge.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `opcode` in 3: RI[11:9]. Valid from the DECODE cycle onwards. 000 ST, 001 LD, 010 ADD, 011 BR, 100 BZ, 101 CLR, 110 DEC, 111 HALT.
- `zero` in 1: AC==0 flag from the datapath.
- `run` in 1: level. 1 means free-running execution.
- `step` in 1: one-cycle pulse requesting a single instruction while `run`=0.
- `mem_ack` in 1: memory completion. Sampled only while `mem_rd` or `mem_wr` is 1.
- `mem_rd` / `mem_wr` out 1: memory read/write request. Held until the ack.
- `ra_sel` out 1: RA source. 0 = CP, 1 = RI address field CD.
- `cp_clr`, `cp_inc`, `cp_load` out 1: CP clear, CP increment, CP load from CD.
- `ri_load` out 1: RI load from memory data.
- `ac_ld`, `ac_add`, `ac_clr`, `ac_dec` out 1: AC load from memory, AC add memory, AC clear, AC decrement.
- `stop` out 1: 1 in HALT.
- `state` out 3: debug. INIT=0, FETCH=1, DECODE=2, MEMRD=3, MEMWR=4, HALT=7.

## Operation
- A registered state plus a registered `step_pend` flag. All outputs are decoded combinationally from state, `opcode`, `zero`, `mem_ack` and the run gate. At most one of the CP strobes and one of the AC strobes is 1 in any cycle.
- **Run gate:** `go = run | step_pend`.
  - `step_pend` sets on a `step` pulse.
  - It clears on the FETCH cycle that completes with `mem_ack`.
  - A `step` arriving while `step_pend` is already 1 is absorbed.
- **INIT:** `cp_clr`=1 → FETCH.
- **FETCH:**
  - If `go`=0: all outputs 0 except `ra_sel`=0; stay in FETCH.
  - Else `mem_rd`=1, `ra_sel`=0. On `mem_ack`: `ri_load`=1, `cp_inc`=1 → DECODE.
- **DECODE** (1 cycle):
  - ST → MEMWR.
  - LD/ADD → MEMRD.
  - BR: `cp_load`=1 → FETCH.
  - BZ: `cp_load`=`zero` → FETCH.
  - CLR: `ac_clr`=1 → FETCH.
  - DEC: `ac_dec`=1 → FETCH.
  - HALT → HALT.
- **MEMRD:** `ra_sel`=1, `mem_rd`=1. On `mem_ack`: `ac_ld`=1 (LD) or `ac_add`=1 (ADD) → FETCH.
  - `opcode` must stay stable; RI is not reloaded.
- **MEMWR:** `ra_sel`=1, `mem_wr`=1. On `mem_ack` → FETCH.
- **HALT:** `stop`=1, all other strobes 0. Left only by `rst`; `run`/`step` are ignored.
- `mem_ack` in any cycle without a request has no effect.

## Timing
- **Reset:**
  - The edge with `rst`=1 forces state=INIT and `step_pend`=0, overriding any transition.
  - After that edge: `cp_clr`=1, `stop`=0, all other outputs 0.
  - The first FETCH follows one cycle after `rst` falls.
- **Reset mid-transfer:** the request drops after the reset edge. A late `mem_ack` is ignored because it is not requested in INIT.
- **Ack timing:**
  - `mem_ack` may be 1 in the same cycle the request is first asserted (zero-wait memory). The request and strobes then last exactly 1 cycle.
  - Each wait state adds 1 cycle. Requests never drop before ack.
- **Latency with zero-wait memory and `run`=1:**
  - BR/BZ/CLR/DEC: 2 cycles.
  - LD/ADD/ST: 3 cycles.
  - HALT: reached 2 cycles after its fetch starts.
- Datapath strobes act on the same rising edge that ends the cycle they are asserted in. CP increments at the end of the fetch, so CD-based `cp_load` in DECODE overrides the incremented value.
- **Single step:** a `step` pulse with `run`=0 executes exactly one full instruction. The FSM then idles in FETCH with no request.
- **`run` falling mid-instruction:** the current instruction completes. The gate is evaluated only in FETCH, and a FETCH with its request already asserted keeps it until ack.

## Test plan
- Reset, `run`=1, `mem_ack` tied 1, opcode 101: after `rst` falls, 1 cycle INIT (`cp_clr`=1), then FETCH/DECODE alternate every cycle, with `ac_clr`=1 in each DECODE.
- LD with ack delayed 2 cycles: `mem_rd`,`ra_sel`=0 for 3 cycles → `ri_load`+`cp_inc` pulse; DECODE; `mem_rd`,`ra_sel`=1 for 3 cycles; `ac_ld` pulses once on the ack cycle.
- BZ: with `zero`=1, `cp_load`=1 in DECODE; with `zero`=0, `cp_load`=0. ST: `mem_wr`=1 for exactly one cycle with zero-wait ack, `mem_rd`=0 throughout.
- `run`=0, three `step` pulses spaced 20 cycles apart on CLR: exactly 3 `ri_load` pulses; state=1 with no request between them; a second `step` during an instruction yields one extra instruction only.
- HALT opcode: `stop`=1 and state=7 from 2 cycles after the fetch start, for 50 cycles despite `run`=1 and `step` pulses. `rst` returns state=0, `stop`=0.
- `rst` asserted during MEMRD with `mem_ack`=0: next cycle state=0, `mem_rd`=0; an ack pulse then produces no `ac_ld`/`ac_add`.
